// File: rtl/mips_defs.sv
// Shared MIPS pipeline constants (register-file geometry and write-back
// source select encodings). Imported by the memory, decode and write-back
// stages so that all of them agree on the encodings.
package mips_defs;

  localparam int          REG_ADDR_W = 5;
  localparam int          NUM_REGS   = 32;
  localparam logic [4:0]  REG_ZERO   = 5'd0;

  localparam logic        RD_SEL_ALU = 1'b0;
  localparam logic        RD_SEL_MEM = 1'b1;

endpackage

// File: rtl/regfile_2r1w.sv
// 32 x WORD_SIZE general-purpose register file: two combinational read
// ports, one synchronous write port, $0 hardwired to zero, and a
// same-cycle write->read bypass.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset (clears all regs)
//   we                 write enable (already qualified for $0 by caller or here)
//   waddr, wdata       write index and value
//   raddr_a, raddr_b   read indices
//   rdata_a, rdata_b   read data (combinational, bypassed)
module regfile_2r1w
  import mips_defs::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [WORD_SIZE-1:0]  wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [WORD_SIZE-1:0]  rdata_a,
  output logic [WORD_SIZE-1:0]  rdata_b
);

  logic [WORD_SIZE-1:0] gpr_q [NUM_REGS];
  logic [WORD_SIZE-1:0] gpr_d [NUM_REGS];
  logic                 wr_ok;

  // $0 is never written, so its storage stays at its reset value of 0.
  assign wr_ok = we && (waddr != REG_ZERO);

  always_comb begin
    gpr_d = gpr_q;
    if (wr_ok) begin
      gpr_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
    end else begin
      gpr_q <= gpr_d;
    end
  end

  // Reads return 0 while in reset so a write presented during reset cannot
  // leak through the bypass path.
  always_comb begin
    if (!rst_n || raddr_a == REG_ZERO)             rdata_a = '0;
    else if (wr_ok && raddr_a == waddr)            rdata_a = wdata;
    else                                           rdata_a = gpr_q[raddr_a];
  end

  always_comb begin
    if (!rst_n || raddr_b == REG_ZERO)             rdata_b = '0;
    else if (wr_ok && raddr_b == waddr)            rdata_b = wdata;
    else                                           rdata_b = gpr_q[raddr_b];
  end

`ifndef SYNTHESIS
  // Simulation-only view of the register contents for debug.
  logic [WORD_SIZE-1:0] dbg_gpr [NUM_REGS];
  assign dbg_gpr = gpr_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (dbg_gpr[REG_ZERO] == '0)
        else $error("regfile: $0 holds a nonzero value");
    end
  end
`endif

endmodule

// File: rtl/writeback.sv
// MIPS write-back stage: selects the ALU or load result from mem->wb,
// writes it into the register file, serves the decode read ports, keeps a
// one-cycle registered record of the last write for ex-stage forwarding,
// and counts architecturally effective writes.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   alu_data_mem_wb, mem_data_mem_wb    candidate write-back values
//   rd_en_mem_wb, rd_addr_mem_wb        destination enable / index
//   rd_data_sel_mem_wb                  1 = load data, 0 = ALU result
//   rs_addr_id, rt_addr_id              decode read indices
//   rs_data_id, rt_data_id              decode read data (combinational)
//   rd_en_wb_ex, rd_addr_wb_ex,
//   rd_data_wb_ex                       registered copy of last cycle's write
//   wr_count                            retired effective-write counter (wraps)
module writeback
  import mips_defs::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int CNT_SIZE  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_SIZE-1:0]  alu_data_mem_wb,
  input  logic [WORD_SIZE-1:0]  mem_data_mem_wb,
  input  logic                  rd_en_mem_wb,
  input  logic [REG_ADDR_W-1:0] rd_addr_mem_wb,
  input  logic                  rd_data_sel_mem_wb,
  input  logic [REG_ADDR_W-1:0] rs_addr_id,
  input  logic [REG_ADDR_W-1:0] rt_addr_id,
  output logic [WORD_SIZE-1:0]  rs_data_id,
  output logic [WORD_SIZE-1:0]  rt_data_id,
  output logic                  rd_en_wb_ex,
  output logic [REG_ADDR_W-1:0] rd_addr_wb_ex,
  output logic [WORD_SIZE-1:0]  rd_data_wb_ex,
  output logic [CNT_SIZE-1:0]   wr_count
);

  logic [WORD_SIZE-1:0]  wb_data;
  logic                  we;

  logic                  rd_en_q,   rd_en_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [WORD_SIZE-1:0]  rd_data_q, rd_data_d;
  logic [CNT_SIZE-1:0]   cnt_q,     cnt_d;

  assign wb_data = (rd_data_sel_mem_wb == RD_SEL_MEM) ? mem_data_mem_wb : alu_data_mem_wb;
  // A write to $0 has no architectural effect, so it is neither stored,
  // forwarded as valid, nor counted.
  assign we      = rd_en_mem_wb && (rd_addr_mem_wb != REG_ZERO);

  regfile_2r1w #(
    .WORD_SIZE (WORD_SIZE)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (rd_addr_mem_wb),
    .wdata   (wb_data),
    .raddr_a (rs_addr_id),
    .raddr_b (rt_addr_id),
    .rdata_a (rs_data_id),
    .rdata_b (rt_data_id)
  );

  // Address/data of the forward record follow the input every cycle;
  // ex only trusts them when rd_en_wb_ex is set.
  always_comb begin
    rd_en_d   = we;
    rd_addr_d = rd_addr_mem_wb;
    rd_data_d = wb_data;
    cnt_d     = cnt_q;
    if (we) begin
      cnt_d = cnt_q + CNT_SIZE'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rd_en_wb_ex   = rd_en_q;
  assign rd_addr_wb_ex = rd_addr_q;
  assign rd_data_wb_ex = rd_data_q;
  assign wr_count      = cnt_q;

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_data_mem_wb;
  logic [31:0] mem_data_mem_wb;
  logic        rd_en_mem_wb;
  logic [4:0]  rd_addr_mem_wb;
  logic        rd_data_sel_mem_wb;
  logic [4:0]  rs_addr_id;
  logic [4:0]  rt_addr_id;
  logic [31:0] rs_data_id;
  logic [31:0] rt_data_id;
  logic        rd_en_wb_ex;
  logic [4:0]  rd_addr_wb_ex;
  logic [31:0] rd_data_wb_ex;
  logic [31:0] wr_count;

  logic [31:0] rs4_data, rt4_data, rd_data4;
  logic        rd_en4;
  logic [4:0]  rd_addr4;
  logic [3:0]  wr_count4;

  int checks;
  int errors;

  writeback #(.WORD_SIZE(32), .CNT_SIZE(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_data_mem_wb    (alu_data_mem_wb),
    .mem_data_mem_wb    (mem_data_mem_wb),
    .rd_en_mem_wb       (rd_en_mem_wb),
    .rd_addr_mem_wb     (rd_addr_mem_wb),
    .rd_data_sel_mem_wb (rd_data_sel_mem_wb),
    .rs_addr_id         (rs_addr_id),
    .rt_addr_id         (rt_addr_id),
    .rs_data_id         (rs_data_id),
    .rt_data_id         (rt_data_id),
    .rd_en_wb_ex        (rd_en_wb_ex),
    .rd_addr_wb_ex      (rd_addr_wb_ex),
    .rd_data_wb_ex      (rd_data_wb_ex),
    .wr_count           (wr_count)
  );

  writeback #(.WORD_SIZE(32), .CNT_SIZE(4)) dut4 (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_data_mem_wb    (alu_data_mem_wb),
    .mem_data_mem_wb    (mem_data_mem_wb),
    .rd_en_mem_wb       (rd_en_mem_wb),
    .rd_addr_mem_wb     (rd_addr_mem_wb),
    .rd_data_sel_mem_wb (rd_data_sel_mem_wb),
    .rs_addr_id         (rs_addr_id),
    .rt_addr_id         (rt_addr_id),
    .rs_data_id         (rs4_data),
    .rt_data_id         (rt4_data),
    .rd_en_wb_ex        (rd_en4),
    .rd_addr_wb_ex      (rd_addr4),
    .rd_data_wb_ex      (rd_data4),
    .wr_count           (wr_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd_en_mem_wb = 1'b0; rd_addr_mem_wb = 5'd0; rd_data_sel_mem_wb = 1'b0;
    alu_data_mem_wb = 32'h0; mem_data_mem_wb = 32'h0;
    rs_addr_id = 5'd1; rt_addr_id = 5'd2;
    step(); step();
    checks++; if (rd_en_wb_ex !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0h want 0", rd_en_wb_ex); end
    checks++; if (rd_addr_wb_ex !== 5'd0) begin errors++; $display("FAIL reset_rd_addr got %0h want 0", rd_addr_wb_ex); end
    checks++; if (rd_data_wb_ex !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %0h want 0", rd_data_wb_ex); end
    checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0h want 0", wr_count); end
    checks++; if (rs_data_id !== 32'd0) begin errors++; $display("FAIL reset_rs got %0h want 0", rs_data_id); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_write();
    rd_en_mem_wb = 1'b1; rd_addr_mem_wb = 5'd5; rd_data_sel_mem_wb = 1'b0;
    alu_data_mem_wb = 32'hDEADBEEF; mem_data_mem_wb = 32'h0BADF00D;
    rs_addr_id = 5'd5; rt_addr_id = 5'd6;
    #1;
    checks++; if (rs_data_id !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_bypass_rs got %h want deadbeef", rs_data_id); end
    checks++; if (rt_data_id !== 32'h0) begin errors++; $display("FAIL alu_other_rt got %h want 0", rt_data_id); end
    step();
    rd_en_mem_wb = 1'b0;
    #1;
    checks++; if (rs_data_id !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_array_rs got %h want deadbeef", rs_data_id); end
    checks++; if (rd_en_wb_ex !== 1'b1) begin errors++; $display("FAIL alu_fwd_en got %0h want 1", rd_en_wb_ex); end
    checks++; if (rd_addr_wb_ex !== 5'd5) begin errors++; $display("FAIL alu_fwd_addr got %0d want 5", rd_addr_wb_ex); end
    checks++; if (rd_data_wb_ex !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_fwd_data got %h want deadbeef", rd_data_wb_ex); end
    checks++; if (wr_count !== 32'd1) begin errors++; $display("FAIL alu_count got %0d want 1", wr_count); end
    step();
  endtask

  task automatic test_load_write();
    rd_en_mem_wb = 1'b1; rd_addr_mem_wb = 5'd31; rd_data_sel_mem_wb = 1'b1;
    alu_data_mem_wb = 32'hFFFFFFFF; mem_data_mem_wb = 32'h12345678;
    rs_addr_id = 5'd5; rt_addr_id = 5'd31;
    #1;
    checks++; if (rt_data_id !== 32'h12345678) begin errors++; $display("FAIL load_bypass_rt got %h want 12345678", rt_data_id); end
    step();
    rd_en_mem_wb = 1'b0; rd_data_sel_mem_wb = 1'b0;
    #1;
    checks++; if (rt_data_id !== 32'h12345678) begin errors++; $display("FAIL load_array_rt got %h want 12345678", rt_data_id); end
    checks++; if (rs_data_id !== 32'hDEADBEEF) begin errors++; $display("FAIL load_keep_r5 got %h want deadbeef", rs_data_id); end
    checks++; if (rd_data_wb_ex !== 32'h12345678) begin errors++; $display("FAIL load_fwd_data got %h want 12345678", rd_data_wb_ex); end
    checks++; if (wr_count !== 32'd2) begin errors++; $display("FAIL load_count got %0d want 2", wr_count); end
    step();
  endtask

  task automatic test_zero_write();
    rd_en_mem_wb = 1'b1; rd_addr_mem_wb = 5'd0; rd_data_sel_mem_wb = 1'b0;
    alu_data_mem_wb = 32'hFFFFFFFF;
    rs_addr_id = 5'd0; rt_addr_id = 5'd0;
    #1;
    checks++; if (rs_data_id !== 32'h0) begin errors++; $display("FAIL zero_bypass_rs got %h want 0", rs_data_id); end
    step();
    rd_en_mem_wb = 1'b0;
    #1;
    checks++; if (rs_data_id !== 32'h0) begin errors++; $display("FAIL zero_after_rs got %h want 0", rs_data_id); end
    checks++; if (rd_en_wb_ex !== 1'b0) begin errors++; $display("FAIL zero_fwd_en got %0h want 0", rd_en_wb_ex); end
    checks++; if (wr_count !== 32'd2) begin errors++; $display("FAIL zero_count got %0d want 2", wr_count); end
    step();
  endtask

  task automatic test_back_to_back();
    rd_en_mem_wb = 1'b1; rd_addr_mem_wb = 5'd7; rd_data_sel_mem_wb = 1'b0;
    alu_data_mem_wb = 32'd1;
    rs_addr_id = 5'd7; rt_addr_id = 5'd7;
    #1;
    checks++; if (rs_data_id !== 32'd1) begin errors++; $display("FAIL b2b_first_rs got %0h want 1", rs_data_id); end
    checks++; if (rt_data_id !== 32'd1) begin errors++; $display("FAIL b2b_first_rt got %0h want 1", rt_data_id); end
    step();
    alu_data_mem_wb = 32'd2;
    #1;
    checks++; if (rs_data_id !== 32'd2) begin errors++; $display("FAIL b2b_second_rs got %0h want 2", rs_data_id); end
    checks++; if (rt_data_id !== 32'd2) begin errors++; $display("FAIL b2b_second_rt got %0h want 2", rt_data_id); end
    step();
    // Idle cycle with unknown data: nothing may change.
    rd_en_mem_wb = 1'b0; rd_data_sel_mem_wb = 1'b1;
    alu_data_mem_wb = 32'hxxxxxxxx; mem_data_mem_wb = 32'hxxxxxxxx;
    #1;
    checks++; if (rs_data_id !== 32'd2) begin errors++; $display("FAIL b2b_idle_rs got %0h want 2", rs_data_id); end
    checks++; if (wr_count !== 32'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", wr_count); end
    step();
    #1;
    checks++; if (rt_data_id !== 32'd2) begin errors++; $display("FAIL b2b_hold_rt got %0h want 2", rt_data_id); end
    checks++; if (rd_en_wb_ex !== 1'b0) begin errors++; $display("FAIL b2b_idle_fwd_en got %0h want 0", rd_en_wb_ex); end
    checks++; if (wr_count !== 32'd4) begin errors++; $display("FAIL b2b_hold_count got %0d want 4", wr_count); end
    alu_data_mem_wb = 32'h0; mem_data_mem_wb = 32'h0; rd_data_sel_mem_wb = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int bad;
    // A write in flight when reset lands must be discarded.
    rd_en_mem_wb = 1'b1; rd_addr_mem_wb = 5'd9; alu_data_mem_wb = 32'h55; rd_data_sel_mem_wb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_en_wb_ex !== 1'b0) begin errors++; $display("FAIL mid_reset_fwd_en got %0h want 0", rd_en_wb_ex); end
    checks++; if (rd_addr_wb_ex !== 5'd0) begin errors++; $display("FAIL mid_reset_fwd_addr got %0d want 0", rd_addr_wb_ex); end
    checks++; if (rd_data_wb_ex !== 32'd0) begin errors++; $display("FAIL mid_reset_fwd_data got %h want 0", rd_data_wb_ex); end
    checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL mid_reset_count got %0d want 0", wr_count); end
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      rs_addr_id = 5'(r); rt_addr_id = 5'(r);
      #1;
      if (rs_data_id !== 32'd0 || rt_data_id !== 32'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_reset_regs nonzero_regs %0d want 0", bad); end
    step();
    rst_n = 1'b1;
    rd_en_mem_wb = 1'b0;
    step();
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      rs_addr_id = 5'(r); rt_addr_id = 5'(31 - r);
      #1;
      if (rs_data_id !== 32'd0 || rt_data_id !== 32'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL post_reset_regs nonzero_regs %0d want 0", bad); end
    checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL post_reset_count got %0d want 0", wr_count); end
  endtask

  task automatic test_counter_wrap();
    rd_data_sel_mem_wb = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      rd_en_mem_wb = 1'b1; rd_addr_mem_wb = 5'(i); alu_data_mem_wb = 32'(i * 3);
    end
    step();
    rd_en_mem_wb = 1'b0;
    rs_addr_id = 5'd17; rt_addr_id = 5'd4;
    #1;
    checks++; if (wr_count4 !== 4'd1) begin errors++; $display("FAIL wrap_count4 got %0d want 1", wr_count4); end
    checks++; if (wr_count !== 32'd17) begin errors++; $display("FAIL wrap_count32 got %0d want 17", wr_count); end
    checks++; if (rs_data_id !== 32'd51) begin errors++; $display("FAIL wrap_r17 got %0d want 51", rs_data_id); end
    checks++; if (rt_data_id !== 32'd12) begin errors++; $display("FAIL wrap_r4 got %0d want 12", rt_data_id); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu_write();
    test_load_write();
    test_zero_write();
    test_back_to_back();
    test_reset_midrun();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
